multicycle_ctrl: RTL and testbench

// - Multicycle control unit for the 32-bit MIPS-subset CPU core.
// - Decodes IR opcode/funct and sequences PC, IR, register file, ALU and memory over 3-5 cycles.
// - Stalls on a memory-ready handshake and counts retired instructions.
// - Sits beside the datapath inside CPU; all datapath mux selects and write strobes come from here.

---
 rtl/multicycle_ctrl_pkg.sv | 48 ++++
 rtl/multicycle_ctrl_alu_ctrl_decode.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode/funct constants, ALU control codes and ALU operation classes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_HALT    = 4'd12
  } state_e;

  // ALU operation class handed from the FSM to the ALU control decoder
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/multicycle_ctrl_alu_ctrl_decode.sv
// Combinational ALU control: maps the FSM's ALU operation class plus the
// R-type funct field onto the 4-bit ALU control code, and flags whether the
// funct field names a supported R-type operation.
module alu_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o,
  output logic       funct_valid_o
);

  logic [3:0] funct_ctl;

  // Funct decode, independent of the current operation class
  always_comb begin
    funct_ctl     = ALU_AND;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  funct_ctl = ALU_ADD;
      FN_SUB:  funct_ctl = ALU_SUB;
      FN_AND:  funct_ctl = ALU_AND;
      FN_OR:   funct_ctl = ALU_OR;
      FN_SLT:  funct_ctl = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  // Select the ALU code by operation class; idle states drive 0000
  always_comb begin
    alu_ctl_o = 4'b0000;
    case (aluop_i)
      ALUOP_ADD:   alu_ctl_o = ALU_ADD;
      ALUOP_SUB:   alu_ctl_o = ALU_SUB;
      ALUOP_FUNCT: alu_ctl_o = funct_ctl;
      default:     alu_ctl_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the MIPS-subset core: state register,
// next-state logic, Moore output decode and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [3:0]       alu_ctl_o,
  output logic [1:0]       pc_source_o,
  output logic             halted_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             mem_ready;
  logic             funct_valid;
  aluop_e           aluop;
  logic             pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

  // Zero only gates the PC enable in the datapath; the controller ignores it
  logic unused_zero;
  assign unused_zero = zero_i;

  assign mem_ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

  alu_ctrl_decode u_alu_dec (
    .aluop_i       (aluop),
    .funct_i       (funct_i),
    .alu_ctl_o     (alu_ctl_o),
    .funct_valid_o (funct_valid)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_d = funct_valid ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; only PCWrite/IRWrite in FETCH follow MemReady
  always_comb begin
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    iord_o          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write       = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    pc_source_o     = 2'd0;
    aluop           = ALUOP_NONE;
    halted_o        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b_o = 2'd1;
        aluop       = ALUOP_ADD;
        pc_write    = mem_ready;
        ir_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b_o = 2'd3;
        aluop       = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        aluop       = ALUOP_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord_o   = 1'b1;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord_o    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        aluop       = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o   = 1'b1;
        aluop         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source_o   = 2'd1;
      end
      S_JUMP: begin
        pc_write    = 1'b1;
        pc_source_o = 2'd2;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_HALT:   halted_o  = 1'b1;
      default:  ;
    endcase
  end

  // Write strobes are held off for as long as reset is asserted
  assign pc_write_o      = pc_write      & ~rst_i;
  assign pc_write_cond_o = pc_write_cond & ~rst_i;
  assign mem_read_o      = mem_read      & ~rst_i;
  assign mem_write_o     = mem_write     & ~rst_i;
  assign ir_write_o      = ir_write      & ~rst_i;
  assign reg_write_o     = reg_write     & ~rst_i;

  // Count an instruction each time the FSM returns to FETCH
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                       count_q <= '0;
    else if (state_q != S_FETCH && state_d == S_FETCH) count_q <= count_q + CNT_W'(1);
  end

  assign state_o       = state_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-scenario tasks with inline checks.
module tb_multicycle_ctrl;

  logic        clk, rst;
  logic [5:0]  opcode, funct, opcode2, funct2;
  logic        zero, zero2, mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_ctl, state;
  logic [31:0] instr_count;
  logic        pc_write2, pc_write_cond2, iord2, mem_read2, mem_write2, ir_write2;
  logic        reg_dst2, mem_to_reg2, reg_write2, alu_src_a2, halted2;
  logic [1:0]  alu_src_b2, pc_source2;
  logic [3:0]  alu_ctl2, state2;
  logic [31:0] instr_count2;

  int          total, bad;
  logic [31:0] exp_cnt;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
    .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_ctl_o(alu_ctl),
    .pc_source_o(pc_source), .halted_o(halted), .state_o(state), .instr_count_o(instr_count)
  );

  multicycle_ctrl #(.MEM_WAIT_EN(1'b0), .CNT_W(32)) dut_nw (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode2), .funct_i(funct2), .zero_i(zero2),
    .mem_ready_i(1'b0), .pc_write_o(pc_write2), .pc_write_cond_o(pc_write_cond2),
    .iord_o(iord2), .mem_read_o(mem_read2), .mem_write_o(mem_write2), .ir_write_o(ir_write2),
    .reg_dst_o(reg_dst2), .mem_to_reg_o(mem_to_reg2), .reg_write_o(reg_write2),
    .alu_src_a_o(alu_src_a2), .alu_src_b_o(alu_src_b2), .alu_ctl_o(alu_ctl2),
    .pc_source_o(pc_source2), .halted_o(halted2), .state_o(state2), .instr_count_o(instr_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    opcode2 = 6'h00; funct2 = 6'h20; zero2 = 1'b0;
    tick(); tick();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    total++; if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b expected 000000",
                      {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read}); end
    total++; if (instr_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst = 1'b0; #1;
    exp_cnt = 0;
    total++; if ({mem_read, pc_write, ir_write, alu_src_b} !== 5'b11101) begin
      bad++; $display("FAIL fetch_after_release: got %b expected 11101", {mem_read, pc_write, ir_write, alu_src_b}); end
  endtask

  task automatic test_r_add();
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; #1;
    total++; if ({state, alu_ctl, reg_write} !== {4'd0, 4'b0010, 1'b0}) begin
      bad++; $display("FAIL radd_fetch: got st=%0d alu=%b rw=%b expected st=0 alu=0010 rw=0", state, alu_ctl, reg_write); end
    tick();
    total++; if ({state, alu_src_b, pc_write, ir_write} !== {4'd1, 2'd3, 2'b00}) begin
      bad++; $display("FAIL radd_decode: got st=%0d srcb=%0d pcw=%b irw=%b expected st=1 srcb=3 pcw=0 irw=0", state, alu_src_b, pc_write, ir_write); end
    tick();
    total++; if ({state, alu_src_a, alu_src_b, alu_ctl, reg_write} !== {4'd6, 1'b1, 2'd0, 4'b0010, 1'b0}) begin
      bad++; $display("FAIL radd_exec: got st=%0d a=%b b=%0d alu=%b rw=%b expected st=6 a=1 b=0 alu=0010 rw=0", state, alu_src_a, alu_src_b, alu_ctl, reg_write); end
    tick();
    total++; if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd7, 3'b110}) begin
      bad++; $display("FAIL radd_rwb: got st=%0d rw=%b rd=%b m2r=%b expected st=7 rw=1 rd=1 m2r=0", state, reg_write, reg_dst, mem_to_reg); end
    tick(); exp_cnt++;
    total++; if ({state, reg_write, reg_dst} !== {4'd0, 2'b00} || instr_count !== exp_cnt) begin
      bad++; $display("FAIL radd_retire: got st=%0d rw=%b rd=%b cnt=%0d expected st=0 rw=0 rd=0 cnt=%0d", state, reg_write, reg_dst, instr_count, exp_cnt); end
  endtask

  task automatic test_alu_funct();
    logic [5:0] fn_tab [4];
    logic [3:0] ctl_tab [4];
    fn_tab  = '{6'h22, 6'h24, 6'h25, 6'h2A};
    ctl_tab = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      opcode = 6'h00; funct = fn_tab[i]; #1;
      tick(); tick();
      total++; if (state !== 4'd6 || alu_ctl !== ctl_tab[i]) begin
        bad++; $display("FAIL exec_funct_%0h: got st=%0d alu=%b expected st=6 alu=%b", fn_tab[i], state, alu_ctl, ctl_tab[i]); end
      tick(); tick(); exp_cnt++;
      total++; if (state !== 4'd0 || instr_count !== exp_cnt) begin
        bad++; $display("FAIL funct_retire_%0h: got st=%0d cnt=%0d expected st=0 cnt=%0d", fn_tab[i], state, instr_count, exp_cnt); end
    end
  endtask

  task automatic test_lw_stall();
    opcode = 6'h23; mem_ready = 1'b1; #1;
    tick(); tick();
    total++; if ({state, alu_src_a, alu_src_b, alu_ctl} !== {4'd2, 1'b1, 2'd2, 4'b0010}) begin
      bad++; $display("FAIL lw_memadr: got st=%0d a=%b b=%0d alu=%b expected st=2 a=1 b=2 alu=0010", state, alu_src_a, alu_src_b, alu_ctl); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if ({state, mem_read, iord, reg_write} !== {4'd3, 3'b110}) begin
        bad++; $display("FAIL lw_stall_%0d: got st=%0d mr=%b iord=%b rw=%b expected st=3 mr=1 iord=1 rw=0", i, state, mem_read, iord, reg_write); end
      tick();
    end
    mem_ready = 1'b1; #1;
    total++; if ({state, mem_read, iord} !== {4'd3, 2'b11}) begin
      bad++; $display("FAIL lw_memrd_ready: got st=%0d mr=%b iord=%b expected st=3 mr=1 iord=1", state, mem_read, iord); end
    tick();
    total++; if ({state, reg_write, mem_to_reg, reg_dst, mem_read} !== {4'd4, 4'b1100}) begin
      bad++; $display("FAIL lw_memwb_cycle8: got st=%0d rw=%b m2r=%b rd=%b mr=%b expected st=4 rw=1 m2r=1 rd=0 mr=0", state, reg_write, mem_to_reg, reg_dst, mem_read); end
    tick(); exp_cnt++;
    total++; if (state !== 4'd0 || instr_count !== exp_cnt) begin
      bad++; $display("FAIL lw_retire: got st=%0d cnt=%0d expected st=0 cnt=%0d", state, instr_count, exp_cnt); end
  endtask

  task automatic test_sw_addi_j();
    opcode = 6'h2B; mem_ready = 1'b1; #1;
    tick(); tick(); mem_ready = 1'b0; tick();
    total++; if ({state, mem_write, iord, mem_read} !== {4'd5, 3'b110}) begin
      bad++; $display("FAIL sw_memwr: got st=%0d mw=%b iord=%b mr=%b expected st=5 mw=1 iord=1 mr=0", state, mem_write, iord, mem_read); end
    mem_ready = 1'b1; #1; tick(); exp_cnt++;
    total++; if (state !== 4'd0 || instr_count !== exp_cnt) begin
      bad++; $display("FAIL sw_retire: got st=%0d cnt=%0d expected st=0 cnt=%0d", state, instr_count, exp_cnt); end
    opcode = 6'h08; #1;
    tick(); tick();
    total++; if ({state, alu_src_a, alu_src_b, alu_ctl} !== {4'd10, 1'b1, 2'd2, 4'b0010}) begin
      bad++; $display("FAIL addi_ex: got st=%0d a=%b b=%0d alu=%b expected st=10 a=1 b=2 alu=0010", state, alu_src_a, alu_src_b, alu_ctl); end
    tick();
    total++; if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd11, 3'b100}) begin
      bad++; $display("FAIL addi_wb: got st=%0d rw=%b rd=%b m2r=%b expected st=11 rw=1 rd=0 m2r=0", state, reg_write, reg_dst, mem_to_reg); end
    tick(); exp_cnt++;
    opcode = 6'h02; #1;
    tick(); tick();
    total++; if ({state, pc_write, pc_source, pc_write_cond} !== {4'd9, 1'b1, 2'd2, 1'b0}) begin
      bad++; $display("FAIL jump: got st=%0d pcw=%b src=%0d pwc=%b expected st=9 pcw=1 src=2 pwc=0", state, pc_write, pc_source, pc_write_cond); end
    tick(); exp_cnt++;
    total++; if (state !== 4'd0 || instr_count !== exp_cnt) begin
      bad++; $display("FAIL jump_retire: got st=%0d cnt=%0d expected st=0 cnt=%0d", state, instr_count, exp_cnt); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'h04; zero = z[0]; #1;
      tick(); tick();
      total++; if ({state, pc_write_cond, pc_source, alu_ctl, pc_write, alu_src_a, alu_src_b} !== {4'd8, 1'b1, 2'd1, 4'b0110, 1'b0, 1'b1, 2'd0}) begin
        bad++; $display("FAIL beq_z%0d: got st=%0d pwc=%b src=%0d alu=%b pcw=%b expected st=8 pwc=1 src=1 alu=0110 pcw=0", z, state, pc_write_cond, pc_source, alu_ctl, pc_write); end
      tick(); exp_cnt++;
      total++; if (state !== 4'd0 || instr_count !== exp_cnt) begin
        bad++; $display("FAIL beq_retire_z%0d: got st=%0d cnt=%0d expected st=0 cnt=%0d", z, state, instr_count, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23; mem_ready = 1'b1; #1;
    tick(); tick(); mem_ready = 1'b0; tick();
    total++; if (state !== 4'd3) begin bad++; $display("FAIL mid_pre_memrd: got st=%0d expected 3", state); end
    #2; rst = 1'b1; #1;
    total++; if ({state, pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read} !== 10'b0 || instr_count !== 32'd0) begin
      bad++; $display("FAIL mid_reset_async: got st=%0d strobes=%b cnt=%0d expected st=0 strobes=000000 cnt=0", state,
                      {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read}, instr_count); end
    mem_ready = 1'b1;
    tick();
    total++; if ({state, pc_write, ir_write, mem_read} !== 7'b0) begin
      bad++; $display("FAIL mid_reset_held: got st=%0d pcw=%b irw=%b mr=%b expected all 0", state, pc_write, ir_write, mem_read); end
    rst = 1'b0; exp_cnt = 0;
    opcode = 6'h00; funct = 6'h20; #1;
    tick();
    total++; if (state !== 4'd1 || instr_count !== 32'd0) begin
      bad++; $display("FAIL mid_release: got st=%0d cnt=%0d expected st=1 cnt=0", state, instr_count); end
    tick(); tick(); tick(); exp_cnt++;
  endtask

  task automatic test_halt();
    opcode = 6'h3F; mem_ready = 1'b1; #1;
    tick(); tick();
    total++; if (state !== 4'd12 || halted !== 1'b1) begin
      bad++; $display("FAIL halt_entry: got st=%0d halted=%b expected st=12 halted=1", state, halted); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read} !== 6'b0 ||
                   state !== 4'd12 || halted !== 1'b1 || instr_count !== exp_cnt) begin
        bad++; $display("FAIL halt_hold_%0d: got st=%0d h=%b strobes=%b cnt=%0d expected st=12 h=1 strobes=000000 cnt=%0d", i, state, halted,
                        {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read}, instr_count, exp_cnt); end
    end
    rst = 1'b1; #1;
    total++; if (halted !== 1'b0 || state !== 4'd0) begin
      bad++; $display("FAIL halt_cleared: got st=%0d halted=%b expected st=0 halted=0", state, halted); end
    tick(); rst = 1'b0; exp_cnt = 0;
    opcode = 6'h00; funct = 6'h3F; #1;
    tick(); tick();
    total++; if (state !== 4'd12 || halted !== 1'b1 || instr_count !== 32'd0) begin
      bad++; $display("FAIL halt_bad_funct: got st=%0d halted=%b cnt=%0d expected st=12 halted=1 cnt=0", state, halted, instr_count); end
  endtask

  task automatic test_no_wait();
    logic [5:0] op_tab [8];
    logic [5:0] fn_tab [8];
    int         lat_tab [8];
    int         exp_sum, act_sum, cyc, timeouts;
    op_tab  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h00, 6'h00};
    fn_tab  = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h2A};
    lat_tab = '{4, 5, 4, 3, 3, 4, 4, 4};
    exp_sum = 0; act_sum = 0; timeouts = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      opcode2 = op_tab[i % 8]; funct2 = fn_tab[i % 8]; zero2 = i[0];
      exp_sum += lat_tab[i % 8];
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (state2 != 4'd0 && cyc < 12);
      act_sum += cyc;
      if (cyc >= 12) begin
        timeouts++;
        break;
      end
    end
    total++; if (timeouts !== 0) begin bad++; $display("FAIL nowait_timeout: got %0d timeouts expected 0", timeouts); end
    total++; if (instr_count2 !== 32'd1000) begin bad++; $display("FAIL nowait_count: got %0d expected 1000", instr_count2); end
    total++; if (act_sum !== exp_sum) begin bad++; $display("FAIL nowait_cycles: got %0d expected %0d", act_sum, exp_sum); end
    total++; if (halted2 !== 1'b0) begin bad++; $display("FAIL nowait_halted: got %b expected 0", halted2); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_r_add();
    test_alu_funct();
    test_lw_stall();
    test_sw_addi_j();
    test_beq();
    test_reset_mid();
    test_halt();
    test_no_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
